// File: rtl/nn_mem_pkg.sv
// Shared defaults and types for the NN controller's kernel/weight memory responders.
package nn_mem_pkg;

  localparam int NN_NUM_ADDR = 5;
  localparam int NN_DATA_W   = 32;

  typedef enum logic {MEM_CLEAR, MEM_READY} mem_state_t;

  typedef logic [NN_DATA_W-1:0] mem_word_t;

endpackage

// File: rtl/nn_mem_array.sv
// DEPTH x DATA_W storage, one port, write wins over read; registered read data, 1-cycle latency.
// Read register holds when no read is issued, so it can be swapped for an SRAM macro with a hold latch.
module nn_mem_array #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rdata <= '0;
    else if (re && !we)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/nn_mem_responder.sv
// Memory-side responder for one NN controller memory port: self-clearing storage, 1-cycle reads.
// Accesses while the clear sweep runs (busy) are refused and flagged; there is no other backpressure.
module nn_mem_responder
  import nn_mem_pkg::*;
#(
  parameter int NUM_ADDR = NN_NUM_ADDR,
  parameter int DATA_W   = NN_DATA_W,
  parameter int DEPTH    = 32,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CSB,
  input  logic                WEB,
  input  logic                OEB,
  input  logic [NUM_ADDR-1:0] ADD,
  input  logic [DATA_W-1:0]   DATA_IN,
  output logic [DATA_W-1:0]   DATA_OUT,
  output logic                rd_valid,
  output logic                busy,
  output logic                err_oe_wr,
  output logic                err_drop,
  output logic                err_addr,
  output logic [CNT_W-1:0]    rd_cnt,
  output logic [CNT_W-1:0]    wr_cnt
);

  localparam logic [NUM_ADDR:0]   DEPTH_X = (NUM_ADDR+1)'(DEPTH);
  localparam logic [NUM_ADDR-1:0] LAST    = NUM_ADDR'(DEPTH - 1);

  mem_state_t          state, state_nxt;
  logic [NUM_ADDR-1:0] ptr, ptr_nxt;
  logic                sel, in_range, acc_rd, acc_wr;
  logic                arr_we, arr_re;
  logic [NUM_ADDR-1:0] arr_addr;
  logic [DATA_W-1:0]   arr_wdata, rd_reg;

  assign busy     = (state == MEM_CLEAR);
  assign sel      = !CSB && !rst;
  assign in_range = ({1'b0, ADD} < DEPTH_X);
  assign acc_wr   = sel && !busy && in_range && !WEB;
  assign acc_rd   = sel && !busy && in_range && WEB;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MEM_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // During the sweep the storage port is owned by the clear pointer.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    arr_we    = acc_wr;
    arr_re    = acc_rd;
    arr_addr  = ADD;
    arr_wdata = DATA_IN;
    case (state)
      MEM_CLEAR: begin
        arr_we    = 1'b1;
        arr_re    = 1'b0;
        arr_addr  = ptr;
        arr_wdata = '0;
        if (ptr == LAST)
          state_nxt = MEM_READY;
        else
          ptr_nxt = ptr + 1'b1;
      end
      MEM_READY: ;
      default: state_nxt = MEM_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid  <= 1'b0;
      err_oe_wr <= 1'b0;
      err_drop  <= 1'b0;
      err_addr  <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      rd_valid <= acc_rd;
      if (acc_wr && !OEB)          err_oe_wr <= 1'b1;
      if (sel && busy)             err_drop  <= 1'b1;
      if (sel && !busy && !in_range) err_addr <= 1'b1;
      if (acc_rd && rd_cnt != '1)  rd_cnt <= rd_cnt + 1'b1;
      if (acc_wr && wr_cnt != '1)  wr_cnt <= wr_cnt + 1'b1;
    end
  end

  nn_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (NUM_ADDR)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (rd_reg)
  );

  // Output enable only gates the registered word; it never touches storage.
  assign DATA_OUT = OEB ? '0 : rd_reg;

endmodule

// File: tb/tb_nn_mem_responder.sv
// Drives a 32-deep/16-bit-counter and a 20-deep/4-bit-counter responder with identical stimulus,
// comparing both against an abstract per-instance model and a read-data scoreboard.
module tb_nn_mem_responder;

  logic        clk;
  logic        rst, CSB, WEB, OEB;
  logic [4:0]  ADD;
  logic [31:0] DATA_IN;

  logic [31:0] b_dout, s_dout;
  logic        b_rdv, b_busy, b_eoe, b_edr, b_ead;
  logic        s_rdv, s_busy, s_eoe, s_edr, s_ead;
  logic [15:0] b_rc, b_wc;
  logic [3:0]  s_rc, s_wc;

  nn_mem_responder #(.NUM_ADDR(5), .DATA_W(32), .DEPTH(32), .CNT_W(16)) u_big (
    .clk(clk), .rst(rst), .CSB(CSB), .WEB(WEB), .OEB(OEB), .ADD(ADD), .DATA_IN(DATA_IN),
    .DATA_OUT(b_dout), .rd_valid(b_rdv), .busy(b_busy), .err_oe_wr(b_eoe),
    .err_drop(b_edr), .err_addr(b_ead), .rd_cnt(b_rc), .wr_cnt(b_wc));

  nn_mem_responder #(.NUM_ADDR(5), .DATA_W(32), .DEPTH(20), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .CSB(CSB), .WEB(WEB), .OEB(OEB), .ADD(ADD), .DATA_IN(DATA_IN),
    .DATA_OUT(s_dout), .rd_valid(s_rdv), .busy(s_busy), .err_oe_wr(s_eoe),
    .err_drop(s_edr), .err_addr(s_ead), .rd_cnt(s_rc), .wr_cnt(s_wc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          started = 0;
  int          m_depth [2] = '{32, 20};
  int          m_cmax  [2] = '{65535, 15};
  logic [31:0] m_mem   [2][32];
  int          m_busy  [2];
  logic [31:0] m_rreg  [2];
  bit          m_rdv [2], m_eoe [2], m_edr [2], m_ead [2];
  int          m_rc [2], m_wc [2];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  task automatic chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL inst%0d %s: got %h expected %h at %0t", i, nm, act, exp, $time);
    end
  endtask

  // Abstract model of one rising edge, applied with the inputs that edge sampled.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_rdv[i] = 0;
      if (rst) begin
        started   = 1;
        m_busy[i] = m_depth[i];
        m_rreg[i] = '0;
        m_eoe[i] = 0; m_edr[i] = 0; m_ead[i] = 0;
        m_rc[i] = 0;  m_wc[i] = 0;
        for (int k = 0; k < 32; k++) m_mem[i][k] = '0;
      end else if (m_busy[i] > 0) begin
        if (!CSB) m_edr[i] = 1;
        m_busy[i]--;
      end else if (!CSB) begin
        if (int'(ADD) >= m_depth[i]) begin
          m_ead[i] = 1;
        end else if (!WEB) begin
          m_mem[i][ADD] = DATA_IN;
          if (m_wc[i] < m_cmax[i]) m_wc[i]++;
          if (!OEB) m_eoe[i] = 1;
        end else begin
          m_rreg[i] = m_mem[i][ADD];
          m_rdv[i]  = 1;
          if (m_rc[i] < m_cmax[i]) m_rc[i]++;
          if (i == 0) q0.push_back(m_rreg[i]);
          else        q1.push_back(m_rreg[i]);
        end
      end
    end
  endtask

  task automatic mon(input int i, input logic b, input logic v, input logic [31:0] d,
                     input logic e1, input logic e2, input logic e3,
                     input logic [31:0] rc, input logic [31:0] wc);
    logic [31:0] exp;
    chk(i, "busy", 32'(b), 32'(m_busy[i] > 0));
    chk(i, "rd_valid", 32'(v), 32'(m_rdv[i]));
    chk(i, "err_oe_wr", 32'(e1), 32'(m_eoe[i]));
    chk(i, "err_drop", 32'(e2), 32'(m_edr[i]));
    chk(i, "err_addr", 32'(e3), 32'(m_ead[i]));
    chk(i, "rd_cnt", rc, 32'(m_rc[i]));
    chk(i, "wr_cnt", wc, 32'(m_wc[i]));
    chk(i, "data_out", d, OEB ? 32'h0 : m_rreg[i]);
    if (v) begin
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL inst%0d rd_scoreboard: got rd_valid with data %h, expected no pending read", i, d);
      end else begin
        exp = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk(i, "rd_data", d, OEB ? 32'h0 : exp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      mon(0, b_busy, b_rdv, b_dout, b_eoe, b_edr, b_ead, 32'(b_rc), 32'(b_wc));
      mon(1, s_busy, s_rdv, s_dout, s_eoe, s_edr, s_ead, 32'(s_rc), 32'(s_wc));
    end
  end

  task automatic cyc(input bit r, input bit c, input bit w, input bit o,
                     input logic [4:0] a, input logic [31:0] d);
    rst = r; CSB = c; WEB = w; OEB = o; ADD = a; DATA_IN = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input bit o);
    cyc(0, 0, 0, o, a, d);
  endtask

  task automatic rd(input logic [4:0] a, input bit o);
    cyc(0, 0, 1, o, a, 32'h0);
  endtask

  task automatic idle(input int n, input bit o);
    for (int k = 0; k < n; k++) cyc(0, 1, 1, o, 5'd0, 32'h0);
  endtask

  task automatic reset_and_sweep();
    cyc(1, 1, 1, 1, 5'd0, 32'h0);
    cyc(1, 1, 1, 1, 5'd0, 32'h0);
    idle(32, 1);
  endtask

  initial begin
    rst = 1; CSB = 1; WEB = 1; OEB = 1; ADD = '0; DATA_IN = '0;

    // Reset sweep, then every word reads back as zero.
    reset_and_sweep();
    for (int a = 0; a < 32; a++) rd(5'(a), 0);
    idle(1, 0);

    // Single write then read.
    wr(5'd5, 32'hDEADBEEF, 1);
    rd(5'd5, 0);
    idle(2, 0);

    // Back-to-back reads, visible and gated.
    wr(5'd0, 32'd11, 1);
    wr(5'd1, 32'd22, 1);
    wr(5'd2, 32'd33, 1);
    rd(5'd0, 0); rd(5'd1, 0); rd(5'd2, 0);
    idle(1, 0);
    rd(5'd0, 1); rd(5'd1, 1); rd(5'd2, 1);
    idle(1, 1);

    // Write with OEB low, write-then-read of same address, out-of-range access.
    wr(5'd7, 32'hA5A5_0007, 0);
    rd(5'd7, 0);
    wr(5'd9, 32'h1234_5678, 1);
    rd(5'd9, 0);
    rd(5'd25, 0);
    wr(5'd25, 32'hFFFF_FFFF, 1);
    idle(2, 0);

    // Counter saturation on the 4-bit instance.
    reset_and_sweep();
    for (int k = 0; k < 17; k++) wr(5'(k % 4), 32'(k + 100), 1);
    idle(1, 1);
    chk(1, "wr_cnt_sat", 32'(s_wc), 32'hF);
    chk(0, "wr_cnt_17", 32'(b_wc), 32'd17);

    // Access during the sweep, then reset mid-sweep restarts it.
    cyc(1, 1, 1, 1, 5'd0, 32'h0);
    idle(2, 1);
    wr(5'd3, 32'hCAFE_F00D, 1);
    idle(6, 1);
    cyc(1, 1, 1, 1, 5'd0, 32'h0);
    idle(32, 1);
    for (int a = 0; a < 8; a++) rd(5'(a), 0);
    idle(1, 0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 3) == 0),
          $urandom_range(0, 1) == 1,
          ($urandom_range(0, 3) == 0),
          5'($urandom_range(0, 31)),
          $urandom);
    end
    idle(3, 0);
    chk(0, "queue_empty", 32'(q0.size()), 32'd0);
    chk(1, "queue_empty", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
